// File: rtl/toy_pkg.sv
// Shared types and constants for the RISC_TOY instruction-fetch slice.
package toy_pkg;

   localparam int TOY_INSTR_W = 32;
   localparam int TOY_PC_W    = 32;
   localparam int PC_STEP     = 4;

   // addi x0, x0, 0 -- presented on FD_INSTR while the queue is empty
   localparam logic [TOY_INSTR_W-1:0] TOY_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [TOY_PC_W-1:0]    pc;
      logic [TOY_INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/toy_sync_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count; flush takes priority over push.
module toy_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; an entry is only read after it has been written, so reset costs area for nothing.
   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/toy_fetch_unit.sv
// Instruction fetch stage: issues word requests, queues responses, hands {PC, INSTR} to decode.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/flushed counters and their output ports.
module toy_fetch_unit
   import toy_pkg::*;
#(
   parameter int              AW       = TOY_PC_W - 2,
   parameter int              DW       = TOY_INSTR_W,
   parameter int              DEPTH    = 4,
   parameter logic [AW+1:0]   RESET_PC = '0
) (
   input  logic            CLK,
   input  logic            RST,
   output logic            IREQ,
   output logic [AW-1:0]   IADDR,
   input  logic [DW-1:0]   INSTR,
   output logic            FD_VALID,
   input  logic            FD_READY,
   output logic [AW+1:0]   FD_PC,
   output logic [DW-1:0]   FD_INSTR,
   input  logic            REDIR_VALID,
   input  logic [AW+1:0]   REDIR_PC,
   output logic            FETCH_EMPTY
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     PERF_FETCHED,
   output logic [31:0]     PERF_FLUSHED
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = AW + 2 + DW;

   logic [AW+1:0]  fetch_pc;
   logic [AW+1:0]  inflight_pc;
   logic           inflight_valid;
   logic           inflight_epoch;
   logic           epoch;
   logic [CW-1:0]  q_count;
   logic           q_full;
   logic           q_empty;
   logic           q_push;
   logic           q_pop;
   logic [EW-1:0]  q_head;
   logic           issue;

   // Reserve a queue slot for every outstanding request so a response always has room.
   assign issue = !RST && !REDIR_VALID && !q_full &&
                  (((CW+1)'(q_count) + (CW+1)'(inflight_valid)) < (CW+1)'(DEPTH));

   assign IREQ        = issue;
   assign IADDR       = fetch_pc[AW+1:2];
   assign q_push      = inflight_valid && (inflight_epoch == epoch);
   assign q_pop       = FD_VALID && FD_READY;
   assign FD_VALID    = !q_empty;
   assign FD_PC       = q_head[EW-1:DW];
   assign FD_INSTR    = q_empty ? DW'(TOY_NOP) : q_head[DW-1:0];
   assign FETCH_EMPTY = q_empty && !inflight_valid;

   toy_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_queue (
      .CLK       (CLK),
      .RST       (RST),
      .push      (q_push),
      .push_data ({inflight_pc, INSTR}),
      .pop       (q_pop),
      .flush     (REDIR_VALID),
      .pop_data  (q_head),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fetch_pc       <= RESET_PC;
         inflight_pc    <= '0;
         inflight_valid <= 1'b0;
         inflight_epoch <= 1'b0;
         epoch          <= 1'b0;
      end else begin
         inflight_valid <= issue;
         if (issue) begin
            inflight_pc    <= fetch_pc;
            inflight_epoch <= epoch;
         end
         // A redirect retags the stream; any response from the old epoch is dropped.
         if (REDIR_VALID) begin
            epoch    <= ~epoch;
            fetch_pc <= {REDIR_PC[AW+1:2], 2'b00};
         end else if (issue) begin
            fetch_pc <= fetch_pc + (AW+2)'(PC_STEP);
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [CW:0]   drop_cnt;
   logic [32:0]   flushed_sum;

   // Words lost to a redirect: queue contents not popped this cycle plus the in-flight word.
   assign drop_cnt    = (CW+1)'(q_count) - (CW+1)'(q_pop) + (CW+1)'(inflight_valid);
   assign flushed_sum = {1'b0, PERF_FLUSHED} + 33'(drop_cnt);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         PERF_FETCHED <= '0;
         PERF_FLUSHED <= '0;
      end else begin
         if (q_pop && (PERF_FETCHED != '1)) PERF_FETCHED <= PERF_FETCHED + 32'd1;
         if (REDIR_VALID) PERF_FLUSHED <= flushed_sum[32] ? '1 : flushed_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_toy_fetch_unit.sv
// Directed self-checking bench for toy_fetch_unit (RESET_PC overridden to 0x40).
module tb_toy_fetch_unit;
   import toy_pkg::*;

   logic        CLK;
   logic        RST;
   logic        IREQ;
   logic [29:0] IADDR;
   logic [31:0] INSTR;
   logic        FD_VALID;
   logic        FD_READY;
   logic [31:0] FD_PC;
   logic [31:0] FD_INSTR;
   logic        REDIR_VALID;
   logic [31:0] REDIR_PC;
   logic        FETCH_EMPTY;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] PERF_FETCHED;
   logic [31:0] PERF_FLUSHED;
`endif

   int n_checks = 0;
   int n_errors = 0;

   toy_fetch_unit #(
      .AW       (30),
      .DW       (32),
      .DEPTH    (4),
      .RESET_PC (32'h40)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .IREQ        (IREQ),
      .IADDR       (IADDR),
      .INSTR       (INSTR),
      .FD_VALID    (FD_VALID),
      .FD_READY    (FD_READY),
      .FD_PC       (FD_PC),
      .FD_INSTR    (FD_INSTR),
      .REDIR_VALID (REDIR_VALID),
      .REDIR_PC    (REDIR_PC),
      .FETCH_EMPTY (FETCH_EMPTY)
`ifdef FETCH_PERF_CNT_EN
      ,
      .PERF_FETCHED (PERF_FETCHED),
      .PERF_FLUSHED (PERF_FLUSHED)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return 32'hC0DE_0000 ^ pc;
   endfunction

   function automatic fetch_entry_t exp_entry(input logic [31:0] pc);
      fetch_entry_t e;
      e.pc    = pc;
      e.instr = instr_of(pc);
      return e;
   endfunction

   // One-cycle memory: data for a request appears in the following cycle; junk otherwise.
   always @(posedge CLK) begin
      INSTR <= IREQ ? instr_of({IADDR, 2'b00}) : 32'hDEAD_BEEF;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
      @(negedge CLK);
      FD_READY    = rdy;
      REDIR_VALID = rv;
      REDIR_PC    = rpc;
      #1;
   endtask

   task automatic expect_head(input string tag, input logic [31:0] pc);
      fetch_entry_t e;
      e = exp_entry(pc);
      check({tag, "_valid"}, FD_VALID, 1);
      check({tag, "_pc"},    FD_PC,    e.pc);
      check({tag, "_instr"}, FD_INSTR, e.instr);
   endtask

   initial begin
      RST         = 1'b1;
      FD_READY    = 1'b0;
      REDIR_VALID = 1'b0;
      REDIR_PC    = '0;
      repeat (3) @(negedge CLK);
      check("rst_ireq",     IREQ,        0);
      check("rst_fd_valid", FD_VALID,    0);
      check("rst_empty",    FETCH_EMPTY, 1);

      // Start-up latency: IREQ cycle 0, FD_VALID cycle 2, then one PC per cycle.
      @(negedge CLK);
      RST      = 1'b0;
      FD_READY = 1'b1;
      #1;
      check("c0_ireq",  IREQ,  1);
      check("c0_iaddr", IADDR, 30'h10);
      cyc(1, 0, 0);
      check("c1_ireq",     IREQ,     1);
      check("c1_iaddr",    IADDR,    30'h11);
      check("c1_fd_valid", FD_VALID, 0);
      for (int k = 0; k < 6; k++) begin
         cyc(1, 0, 0);
         expect_head("stream", 32'h40 + 32'(4 * k));
      end

      // Decode stalls: queue fills to 4, head holds at 0x58.
      for (int k = 0; k < 10; k++) begin
         cyc(0, 0, 0);
         expect_head("stall", 32'h58);
      end
      check("full_ireq",  IREQ,        0);
      check("full_empty", FETCH_EMPTY, 0);

      // Release: four queued words drain back-to-back, stream continues without a bubble.
      cyc(1, 0, 0);
      expect_head("drain0", 32'h58);
      check("drain0_ireq", IREQ, 0);
      cyc(1, 0, 0);
      expect_head("drain1", 32'h5C);
      check("drain1_ireq", IREQ, 1);
      cyc(1, 0, 0);
      expect_head("drain2", 32'h60);
      cyc(1, 0, 0);
      expect_head("drain3", 32'h64);

      // Build 3 queued + 1 in flight, then redirect to 0x100.
      cyc(0, 0, 0);
      expect_head("pre_redir", 32'h68);
      check("pre_redir_iaddr", IADDR, 30'h1D);
      cyc(0, 1, 32'h100);
      check("redir_ireq", IREQ, 0);
      cyc(1, 0, 0);
      check("redir_t1_valid", FD_VALID,    0);
      check("redir_t1_empty", FETCH_EMPTY, 1);
      check("redir_t1_ireq",  IREQ,        1);
      check("redir_t1_iaddr", IADDR,       30'h40);
      cyc(1, 0, 0);
      check("redir_t2_valid", FD_VALID, 0);
      check("redir_t2_iaddr", IADDR,    30'h41);
      cyc(1, 0, 0);
      expect_head("redir_t3", 32'h100);
`ifdef FETCH_PERF_CNT_EN
      check("perf_flushed_a", PERF_FLUSHED, 4);
`endif
      cyc(1, 0, 0);
      expect_head("redir_t4", 32'h104);

      // Redirect coincident with an accepted pop: the popped word is delivered.
      cyc(1, 1, 32'h200);
      expect_head("pop_redir", 32'h108);
      check("pop_redir_ireq", IREQ, 0);
      cyc(1, 0, 0);
      check("pop_redir_t1_valid", FD_VALID,    0);
      check("pop_redir_t1_empty", FETCH_EMPTY, 1);
      check("pop_redir_t1_iaddr", IADDR,       30'h80);
      cyc(1, 0, 0);
      check("pop_redir_t2_valid", FD_VALID, 0);
      cyc(1, 0, 0);
      expect_head("pop_redir_t3", 32'h200);
`ifdef FETCH_PERF_CNT_EN
      check("perf_flushed_b", PERF_FLUSHED, 5);
`endif
      cyc(1, 0, 0);
      expect_head("pop_redir_t4", 32'h204);

      // Unaligned target: low two bits are ignored.
      cyc(1, 1, 32'h102);
      expect_head("unal_redir", 32'h208);
      cyc(1, 0, 0);
      check("unal_iaddr", IADDR,    30'h40);
      check("unal_valid", FD_VALID, 0);
      cyc(1, 0, 0);
      check("unal_t2_valid", FD_VALID, 0);
      cyc(1, 0, 0);
      expect_head("unal_t3", 32'h100);

      // Back-to-back redirects: only the second target is fetched.
      cyc(1, 1, 32'h300);
      expect_head("b2b_first", 32'h104);
      cyc(1, 1, 32'h400);
      check("b2b_second_ireq",  IREQ,     0);
      check("b2b_second_valid", FD_VALID, 0);
      cyc(1, 0, 0);
      check("b2b_iaddr", IADDR,    30'h100);
      check("b2b_valid", FD_VALID, 0);
`ifdef FETCH_PERF_CNT_EN
      check("perf_flushed_c", PERF_FLUSHED, 7);
`endif
      cyc(1, 0, 0);
      check("b2b_t2_valid", FD_VALID, 0);
      cyc(1, 0, 0);
      expect_head("b2b_t3", 32'h400);
      cyc(1, 0, 0);
      expect_head("b2b_t4", 32'h404);

      // Reset mid-stream: outputs drop at once, fetch restarts from RESET_PC.
      cyc(1, 0, 0);
      check("pre_rst_ireq", IREQ, 1);
      RST = 1'b1;
      #1;
      check("mid_rst_ireq",  IREQ,        0);
      check("mid_rst_valid", FD_VALID,    0);
      check("mid_rst_empty", FETCH_EMPTY, 1);
`ifdef FETCH_PERF_CNT_EN
      check("mid_rst_perf_fetched", PERF_FETCHED, 0);
      check("mid_rst_perf_flushed", PERF_FLUSHED, 0);
`endif
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("restart_ireq",  IREQ,  1);
      check("restart_iaddr", IADDR, 30'h10);
      cyc(1, 0, 0);
      check("restart_t1_valid", FD_VALID, 0);
      cyc(1, 0, 0);
      expect_head("restart_t2", 32'h40);
      cyc(1, 0, 0);
      expect_head("restart_t3", 32'h44);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
